g_orn_filt: RTL and testbench
=============================

// Module: g_orn_filt
// PURPOSE
//  Parametrised successor to the fixed 3-input mixed-polarity OR macro.
//  - WIDTH-input OR with a per-input active-low mask.
//  - Optional per-input synchroniser on every input.
//  - Stability filter: the output changes only after the OR term holds for FILT cycles.
//  - Registered output, plus rise/fall event pulses.
//  - Used in schematic-capture designs for qualifying async status/fault lines.
// PARAMETERS
//  WIDTH        3        number of inputs, 1..32
//  INV_MASK     3'b011   bit i=1 -> input A[i] is active-low (inverted before OR)
//  SYNC_STAGES  2        synchroniser flops per input, 0 (bypass) or 2..4
//  FILT         4        consecutive agreeing cycles required to toggle Y, 1..255
// PORTS
//  CK    in   1      clock, rising edge
//  RN    in   1      asynchronous active-low reset
//  A     in   WIDTH  raw inputs, may be asynchronous to CK
//  EN    in   1      filter enable; 0 freezes Y and clears qualification
//  Y     out  1      filtered OR result, registered
//  YP    out  1      one-cycle pulse on each Y 0->1
//  YF    out  1      one-cycle pulse on each Y 1->0
//  STKY  out  1      sticky flag (present only with G_ORN_STICKY_EN)
//  CLR   in   1      sticky clear (present only with G_ORN_STICKY_EN)
// BEHAVIOUR
//  - Reset is asynchronous, active-low. RN=0 forces:
//      Y=0, YP=0, YF=0, STKY=0; FSM=LOW; cnt=0.
//      Sync flops load INV_MASK, so the OR term reads 0 out of reset.
//  - Term: s = |(A_sync ^ INV_MASK), where A_sync is A after SYNC_STAGES flops.
//  - Counter: cnt is $clog2(FILT+1) bits wide and saturates at FILT; it never wraps.
//  - FSM states LOW, QUAL_HI, HIGH, QUAL_LO. Every transition below requires EN=1.
//      LOW:     s=1 -> QUAL_HI, cnt=1; if FILT=1, go directly to HIGH instead.
//      QUAL_HI: s=0 -> LOW, cnt=0. Otherwise cnt++.
//               When cnt+1==FILT -> HIGH: Y=1 and YP=1 for that one cycle.
//      HIGH:    s=0 -> QUAL_LO, cnt=1; if FILT=1, go directly to LOW (Y=0, YF=1).
//      QUAL_LO: s=1 -> HIGH, cnt=0. Otherwise cnt++.
//               When cnt+1==FILT -> LOW: Y=0 and YF=1.
//  - Latency: an input edge that holds reaches Y after exactly SYNC_STAGES+FILT cycles.
//  - Glitches: any pulse on s shorter than FILT cycles leaves Y unchanged and pulses no output.
//  - EN=0 (checked every cycle):
//      QUAL_HI returns to LOW; QUAL_LO returns to HIGH; cnt=0.
//      Y holds its value; YP=YF=0. Sync flops keep running.
//  - EN 0->1: qualification restarts from cnt=0 on the next cycle.
//  - YP and YF are never both 1 in the same cycle. Each is 1 for exactly one cycle per Y edge.
//  - Reset mid-qualification: the partial count is discarded and Y=0 immediately.
//  - Input changes while in QUAL_*: only s (the OR result) matters, not which input changed.
// CONFIGURATION
//  Macro G_ORN_STICKY_EN.
//  - Defined:
//      STKY sets on the cycle YP fires and holds until CLR=1 (synchronous clear).
//      If YP and CLR are 1 in the same cycle, set wins: STKY=1.
//      STKY reset value is 0.
//  - Undefined:
//      STKY and CLR ports are absent; no sticky logic is synthesised.
// TESTING  (WIDTH=3, INV_MASK=3'b011, SYNC_STAGES=2, FILT=4 unless noted)
//  1. Release reset with A=3'b011, then set A=3'b111 and hold
//     -> Y=1 exactly 6 cycles later; YP high for that one cycle only.
//  2. From Y=0: A=3'b111 for 3 cycles, then A=3'b011
//     -> Y stays 0; YP=YF=0 throughout.
//  3. From Y=1: set A=3'b011 and hold
//     -> Y=0 after 6 cycles; YF is a one-cycle pulse.
//     A low glitch of 2 cycles instead -> Y stays 1.
//  4. A=3'b111, then pull RN low 4 cycles later (mid QUAL_HI)
//     -> Y=0 and cnt=0 immediately. After RN release with A held -> Y=1 6 cycles later.
//  5. EN=0 during QUAL_HI for 2 cycles, A held at 3'b111
//     -> Y=1 arrives 4 cycles after EN returns to 1 (the count restarts).
//  6. Build with G_ORN_STICKY_EN, drive a rise then CLR=1 in the YP cycle
//     -> STKY=1. A later CLR=1 alone -> STKY=0.
//     Build with SYNC_STAGES=0, FILT=1 -> Y follows s with 1 cycle of latency.

Source files
------------

// File: rtl/g_orn_filt.sv
// ============================================================================
// g_orn_filt -- qualified mixed-polarity OR of asynchronous status lines
//
// Purpose
//   Combines WIDTH raw (possibly asynchronous) inputs into one filtered,
//   registered status bit. Each input is optionally synchronised, its
//   polarity is normalised with INV_MASK, and the inputs are ORed into a
//   term s. Y follows s only after s has disagreed with Y for FILT
//   consecutive enabled cycles. Rise and fall events are reported as
//   one-cycle pulses.
//
// Parameters
//   WIDTH        number of inputs, 1..32
//   INV_MASK     bit i = 1 -> A[i] is active-low
//   SYNC_STAGES  synchroniser depth per input, 0 (bypass) or 2..4
//   FILT         consecutive agreeing cycles needed to toggle Y, 1..255
//
// Ports
//   CK    in   1      clock, rising edge
//   RN    in   1      asynchronous active-low reset
//   A     in   WIDTH  raw inputs
//   EN    in   1      filter enable; 0 freezes Y and drops qualification
//   Y     out  1      filtered OR result, registered
//   YP    out  1      one-cycle pulse on each Y 0->1
//   YF    out  1      one-cycle pulse on each Y 1->0
//   STKY  out  1      sticky rise flag          (G_ORN_STICKY_EN only)
//   CLR   in   1      synchronous sticky clear  (G_ORN_STICKY_EN only)
//
// Configuration macro
//   G_ORN_STICKY_EN  -- when defined, adds STKY/CLR and the sticky register.
//                       When undefined those ports and that logic are absent.
// ============================================================================
module g_orn_filt #(
  parameter int unsigned      WIDTH       = 3,
  parameter logic [WIDTH-1:0] INV_MASK    = 3'b011,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      FILT        = 4
) (
  input  logic             CK,
  input  logic             RN,
  input  logic [WIDTH-1:0] A,
  input  logic             EN,
  output logic             Y,
  output logic             YP,
  output logic             YF
`ifdef G_ORN_STICKY_EN
  ,
  output logic             STKY,
  input  logic             CLR
`endif
);

  // Counter is just wide enough to hold FILT; cnt+1 is formed one bit wider
  // so the terminal compare never overflows.
  localparam int unsigned    CW        = $clog2(FILT + 1);
  localparam logic [CW-1:0]  FILT_C    = CW'(FILT);
  localparam logic [CW:0]    FILT_X    = (CW + 1)'(FILT);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO  = '0;
  localparam bit             FILT_IS_1 = (FILT == 1);

  // --------------------------------------------------------------------------
  // Input synchroniser chain. w_chain[0] is the raw input and each stage
  // drives the next element; with SYNC_STAGES = 0 the chain is just a wire.
  // Stages reset to INV_MASK so every input reads "inactive" out of reset
  // and the OR term starts at 0.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_chain [SYNC_STAGES+1];
  logic [WIDTH-1:0] w_a_sync;
  logic             w_term;

  assign w_chain[0] = A;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic [WIDTH-1:0] r_q;

      always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
          r_q <= INV_MASK;
        end else begin
          r_q <= w_chain[gi];
        end
      end

      assign w_chain[gi+1] = r_q;
    end
  endgenerate

  assign w_a_sync = w_chain[SYNC_STAGES];

  // Polarity-normalised OR: an input counts as asserted when it differs
  // from its INV_MASK bit.
  assign w_term = |(w_a_sync ^ INV_MASK);

  // --------------------------------------------------------------------------
  // Qualification counter helpers
  // --------------------------------------------------------------------------
  logic [CW-1:0] r_cnt;
  logic [CW:0]   w_cnt_inc;
  logic [CW-1:0] w_cnt_sat;
  logic          w_cnt_done;

  assign w_cnt_inc  = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};
  // Saturate rather than wrap; in normal operation the state leaves
  // qualification before the count could reach FILT.
  assign w_cnt_sat  = (r_cnt == FILT_C) ? r_cnt : w_cnt_inc[CW-1:0];
  assign w_cnt_done = (w_cnt_inc == FILT_X);

  // --------------------------------------------------------------------------
  // Filter FSM with registered outputs
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_QUAL_HI = 2'd1,
    ST_HIGH    = 2'd2,
    ST_QUAL_LO = 2'd3
  } state_t;

  state_t r_state;
  logic   r_y;
  logic   r_yp;
  logic   r_yf;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state <= ST_LOW;
      r_cnt   <= CNT_ZERO;
      r_y     <= 1'b0;
      r_yp    <= 1'b0;
      r_yf    <= 1'b0;
    end else begin
      // Pulses are single-cycle by default; only a completed
      // qualification re-asserts one below.
      r_yp <= 1'b0;
      r_yf <= 1'b0;

      if (!EN) begin
        // Disabled: abandon any qualification in progress and fall back
        // to the stable state matching the current Y. Y itself holds.
        r_cnt <= CNT_ZERO;
        case (r_state)
          ST_QUAL_HI: r_state <= ST_LOW;
          ST_QUAL_LO: r_state <= ST_HIGH;
          default:    r_state <= r_state;
        endcase
      end else begin
        case (r_state)
          ST_LOW: begin
            if (w_term) begin
              if (FILT_IS_1) begin
                r_state <= ST_HIGH;
                r_cnt   <= CNT_ZERO;
                r_y     <= 1'b1;
                r_yp    <= 1'b1;
              end else begin
                r_state <= ST_QUAL_HI;
                r_cnt   <= CNT_ONE;
              end
            end
          end

          ST_QUAL_HI: begin
            if (!w_term) begin
              r_state <= ST_LOW;
              r_cnt   <= CNT_ZERO;
            end else if (w_cnt_done) begin
              r_state <= ST_HIGH;
              r_cnt   <= CNT_ZERO;
              r_y     <= 1'b1;
              r_yp    <= 1'b1;
            end else begin
              r_cnt   <= w_cnt_sat;
            end
          end

          ST_HIGH: begin
            if (!w_term) begin
              if (FILT_IS_1) begin
                r_state <= ST_LOW;
                r_cnt   <= CNT_ZERO;
                r_y     <= 1'b0;
                r_yf    <= 1'b1;
              end else begin
                r_state <= ST_QUAL_LO;
                r_cnt   <= CNT_ONE;
              end
            end
          end

          ST_QUAL_LO: begin
            if (w_term) begin
              r_state <= ST_HIGH;
              r_cnt   <= CNT_ZERO;
            end else if (w_cnt_done) begin
              r_state <= ST_LOW;
              r_cnt   <= CNT_ZERO;
              r_y     <= 1'b0;
              r_yf    <= 1'b1;
            end else begin
              r_cnt   <= w_cnt_sat;
            end
          end

          default: begin
            r_state <= ST_LOW;
            r_cnt   <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  assign Y  = r_y;
  assign YP = r_yp;
  assign YF = r_yf;

`ifdef G_ORN_STICKY_EN
  // --------------------------------------------------------------------------
  // Sticky rise flag: set by the registered YP pulse, cleared by CLR.
  // A set in the same cycle as a clear wins.
  // --------------------------------------------------------------------------
  logic r_stky;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_stky <= 1'b0;
    end else if (r_yp) begin
      r_stky <= 1'b1;
    end else if (CLR) begin
      r_stky <= 1'b0;
    end
  end

  assign STKY = r_stky;
`endif

endmodule

// File: tb/tb_g_orn_filt.sv
// Bench for g_orn_filt. A run-length reference model predicts Y and the
// rise/fall events; predicted events go into a queue that a negedge monitor
// pops whenever the DUT pulses YP or YF. Directed phases pin down the
// documented latencies, then a randomized phase exercises glitches, enable
// drops and resets.
module tb_g_orn_filt;

  localparam int       WIDTH = 3;
  localparam logic [2:0] INV = 3'b011;
  localparam int       SYNC  = 2;
  localparam int       FILT  = 4;

  logic       clk;
  logic       rn;
  logic [2:0] a;
  logic       en;
  logic       y, yp, yf;
`ifdef G_ORN_STICKY_EN
  logic       stky;
  logic       clr;
  bit         stky_m;
`endif

  g_orn_filt #(
    .WIDTH      (WIDTH),
    .INV_MASK   (INV),
    .SYNC_STAGES(SYNC),
    .FILT       (FILT)
  ) dut (
    .CK  (clk),
    .RN  (rn),
    .A   (a),
    .EN  (en),
    .Y   (y),
    .YP  (yp),
    .YF  (yf)
`ifdef G_ORN_STICKY_EN
    ,
    .STKY(stky),
    .CLR (clr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", name, act, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: Y flips once s has disagreed with Y on FILT consecutive
  // enabled clock edges; s is the masked OR of A as sampled SYNC edges ago.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit rise;
    int cyc;
  } ev_t;

  ev_t        ev_q[$];
  ev_t        ev;
  logic [2:0] a_hist[$];
  logic [2:0] a_old;
  bit         s_m;
  bit         y_m;
  bit         yp_m;
  int         run_m;
  int         cyc = 0;
  bit         mon_en = 0;

  initial begin
    y_m   = 0;
    yp_m  = 0;
    run_m = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rn) begin
        y_m   = 0;
        yp_m  = 0;
        run_m = 0;
        ev_q.delete();
        a_hist.delete();
        for (int i = 0; i < SYNC; i++) a_hist.push_back(INV);
`ifdef G_ORN_STICKY_EN
        stky_m = 0;
`endif
      end else begin
`ifdef G_ORN_STICKY_EN
        stky_m = yp_m | (stky_m & ~clr);
`endif
        yp_m = 0;
        a_hist.push_back(a);
        a_old = a_hist.pop_front();
        s_m   = |(a_old ^ INV);
        if (!en) begin
          run_m = 0;
        end else if (s_m != y_m) begin
          run_m++;
          if (run_m == FILT) begin
            y_m   = s_m;
            yp_m  = s_m;
            run_m = 0;
            ev_q.push_back('{rise: s_m, cyc: cyc});
          end
        end else begin
          run_m = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rn) begin
        chk("mon_y", {31'd0, y}, {31'd0, y_m});
        chk("mon_yp_yf_exclusive", {31'd0, yp & yf}, 32'd0);
`ifdef G_ORN_STICKY_EN
        chk("mon_stky", {31'd0, stky}, {31'd0, stky_m});
`endif
        if (yp || yf) begin
          if (ev_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL mon_unexpected_pulse: got yp=%0b yf=%0b expected no pulse (cyc=%0d)", yp, yf, cyc);
          end else begin
            ev = ev_q.pop_front();
            chk("mon_pulse_is_rise", {31'd0, yp}, {31'd0, ev.rise});
            chk("mon_pulse_cycle", cyc, ev.cyc);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int hold;
    rn = 1'b0;
    a  = INV;
    en = 1'b1;
`ifdef G_ORN_STICKY_EN
    clr = 1'b0;
`endif
    step(3);
    chk("reset_y", {31'd0, y}, 32'd0);
    chk("reset_yp", {31'd0, yp}, 32'd0);
    chk("reset_yf", {31'd0, yf}, 32'd0);
    rn = 1'b1;
    mon_en = 1'b1;

    // Rise latency: SYNC + FILT = 6 edges, YP for one cycle.
    step(8);
    a = 3'b111;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      if (i == 5) chk("rise_y_before", {31'd0, y}, 32'd0);
      if (i == 6) begin
        chk("rise_y_at6", {31'd0, y}, 32'd1);
        chk("rise_yp_at6", {31'd0, yp}, 32'd1);
      end
      if (i == 7) chk("rise_yp_after", {31'd0, yp}, 32'd0);
    end

    // Fall latency from Y=1, YF for one cycle.
    step(4);
    a = 3'b011;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      if (i == 5) chk("fall_y_before", {31'd0, y}, 32'd1);
      if (i == 6) begin
        chk("fall_y_at6", {31'd0, y}, 32'd0);
        chk("fall_yf_at6", {31'd0, yf}, 32'd1);
      end
      if (i == 7) chk("fall_yf_after", {31'd0, yf}, 32'd0);
    end

    // High glitch of 3 cycles from Y=0: no change.
    step(4);
    a = 3'b111;
    step(3);
    a = 3'b011;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (i % 3 == 2) chk("glitch_hi_y", {31'd0, y}, 32'd0);
    end

    // Low glitch of 2 cycles from Y=1: no change.
    a = 3'b111;
    step(10);
    a = 3'b011;
    step(2);
    a = 3'b111;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (i % 3 == 2) chk("glitch_lo_y", {31'd0, y}, 32'd1);
    end

    // Reset while Y=1 clears Y immediately.
    rn = 1'b0;
    #1;
    chk("async_reset_y", {31'd0, y}, 32'd0);
    step(1);
    rn = 1'b1;

    // Reset mid-qualification, then full latency after release.
    a = 3'b011;
    step(10);
    a = 3'b111;
    step(4);
    rn = 1'b0;
    #1;
    chk("midqual_reset_y", {31'd0, y}, 32'd0);
    step(2);
    rn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      if (i == 5) chk("post_reset_y_before", {31'd0, y}, 32'd0);
      if (i == 6) chk("post_reset_y_at6", {31'd0, y}, 32'd1);
    end

    // EN drop during QUAL_HI restarts the count.
    a = 3'b011;
    step(10);
    a = 3'b111;
    step(3);
    en = 1'b0;
    step(2);
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      if (i == 3) chk("en_restart_y_before", {31'd0, y}, 32'd0);
      if (i == 4) chk("en_restart_y_at4", {31'd0, y}, 32'd1);
    end

`ifdef G_ORN_STICKY_EN
    // CLR coinciding with YP: set wins. A later lone CLR clears.
    a = 3'b011;
    step(10);
    a = 3'b111;
    step(6);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("stky_set_wins", {31'd0, stky}, 32'd1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("stky_cleared", {31'd0, stky}, 32'd0);
`endif

    // Randomized segments: held values of random length, enable drops,
    // occasional resets.
    for (int seg = 0; seg < 300; seg++) begin
      a    = ($urandom_range(0, 1) != 0) ? INV : 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 2 * FILT + 2);
      for (int k = 0; k < hold; k++) begin
        en = ($urandom_range(0, 15) != 0);
        rn = ($urandom_range(0, 299) != 0);
`ifdef G_ORN_STICKY_EN
        clr = ($urandom_range(0, 7) == 0);
`endif
        step(1);
      end
    end
    rn = 1'b1;
    en = 1'b1;
    step(12);

    chk("event_queue_drained", ev_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
